// File: rtl/root_req_arbiter_pkg.sv
// Shared definitions for the Root engine request arbiter.
package root_req_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_REJ   = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // Q10.10 operand and result widths
  localparam int RADICAND_W = 10;
  localparam int DEGREE_W   = 3;
  localparam int RESULT_W   = 20;

endpackage

// File: rtl/root_req_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward with wrap and
// returns a one-hot grant, its index, and whether anything was requesting.
module root_req_arbiter_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic            o_any,
  output logic [IDXW-1:0] o_idx
);

  logic [IDXW-1:0] w_pos;

  // First requester after the pointer wins; the pointer itself is checked last
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IDXW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/root_req_arbiter.sv
// Shares one serial Q10.10 n-th root engine among NUM_REQ requesters:
// round-robin accept, operand hold towards the engine, timeout watchdog
// with engine reset, and immediate rejection of degree-0 requests.
module root_req_arbiter
  import root_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*RADICAND_W-1:0]  req_radicand,
  input  logic [NUM_REQ*DEGREE_W-1:0]    req_degree,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [RESULT_W-1:0]            resp_data,
  output logic                           resp_err,
  output logic                           eng_in_valid,
  output logic [RADICAND_W-1:0]          eng_in_data_1,
  output logic [DEGREE_W-1:0]            eng_in_data_2,
  input  logic                           eng_out_valid,
  input  logic [RESULT_W-1:0]            eng_out_data,
  output logic                           eng_rst
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]      TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

  state_t                r_state;
  logic [IDXW-1:0]       r_ptr;
  logic [IDXW-1:0]       r_owner;
  logic [RADICAND_W-1:0] r_rad;
  logic [DEGREE_W-1:0]   r_deg;
  logic [TW-1:0]         r_timer;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any;
  logic [IDXW-1:0]       w_idx;
  logic [RADICAND_W-1:0] w_sel_rad;
  logic [DEGREE_W-1:0]   w_sel_deg;
  logic [NUM_REQ-1:0]    w_owner_oh;

  root_req_arbiter_rr_pick #(
    .N    (NUM_REQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any),
    .o_idx   (w_idx)
  );

  // Operands of the requester the picker would accept this cycle
  always_comb begin
    w_sel_rad = '0;
    w_sel_deg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IDXW'(i)) begin
        w_sel_rad = req_radicand[RADICAND_W*i +: RADICAND_W];
        w_sel_deg = req_degree[DEGREE_W*i +: DEGREE_W];
      end
    end
  end

  assign w_owner_oh    = ONE << r_owner;
  // The engine samples its operands combinationally while it computes,
  // so they come straight from the capture registers.
  assign eng_in_data_1 = r_rad;
  assign eng_in_data_2 = r_deg;

  // Arbitration FSM; every output pulse is registered on entry to its state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= IDXW'(NUM_REQ - 1);
      r_owner      <= '0;
      r_rad        <= '0;
      r_deg        <= '0;
      r_timer      <= '0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_rst      <= 1'b1;
    end else begin
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_rst      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            req_ready <= w_grant;
            r_ptr     <= w_idx;
            r_owner   <= w_idx;
            r_rad     <= w_sel_rad;
            r_deg     <= w_sel_deg;
            if (w_sel_deg == '0) begin
              // Degree 0 has no root: answer with an error, engine untouched
              r_state    <= ST_REJ;
              resp_valid <= w_grant;
              resp_err   <= 1'b1;
            end else begin
              r_state      <= ST_ISSUE;
              eng_in_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle still wins over the abort
          if (eng_out_valid) begin
            r_state    <= ST_RESP;
            resp_valid <= w_owner_oh;
            resp_data  <= eng_out_data;
          end else if (r_timer == TMAX) begin
            r_state    <= ST_ABORT;
            resp_valid <= w_owner_oh;
            resp_err   <= 1'b1;
            eng_rst    <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP, ST_REJ, ST_ABORT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
